// File: rtl/round_control_if.sv
// Handshake bundle between the match sequencer and its environment: combat
// event inputs in, sequencing/HUD outputs back.
interface round_control_if;
  logic       start;
  logic       dead_L;
  logic       dead_R;
  logic       collision;
  logic [2:0] board_controller;
  logic       match_reset;
  logic       freeze;
  logic       respawn_L;
  logic       respawn_R;
  logic [3:0] kills_L;
  logic [3:0] kills_R;
  logic [1:0] winner;
  logic [2:0] game_state;

  // Environment side: drives the button and combat events, observes the sequencer.
  modport master (
    output start, dead_L, dead_R, collision, board_controller,
    input  match_reset, freeze, respawn_L, respawn_R,
           kills_L, kills_R, winner, game_state
  );

  // Sequencer side.
  modport slave (
    input  start, dead_L, dead_R, collision, board_controller,
    output match_reset, freeze, respawn_L, respawn_R,
           kills_L, kills_R, winner, game_state
  );
endinterface

// File: rtl/round_control.sv
// Match-level sequencer for the duel game: start/fight/respawn/clash/win flow.
// Define ROUND_CTRL_CLASH_FREEZE_EN to enable the sword-clash freeze state.
module round_control #(
  parameter int RESPAWN_CYCLES = 65_000_000,
  parameter int CLASH_CYCLES   = 16_250_000,
  parameter int WIN_BOARD      = 3,
  parameter int TIMER_W        = 26
) (
  input  logic           clk,
  input  logic           reset,
  round_control_if.slave rc
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FIGHT   = 3'd1,
    RESPAWN = 3'd2,
    CLASH   = 3'd3,
    WIN     = 3'd4
  } state_t;

  localparam logic [TIMER_W-1:0] RESPAWN_LOAD = TIMER_W'(RESPAWN_CYCLES - 1);
  localparam logic signed [2:0]  WIN_POS      = 3'(WIN_BOARD);
  localparam logic signed [2:0]  WIN_NEG      = 3'(-WIN_BOARD);

  state_t             state_reg;
  logic [TIMER_W-1:0] timer_reg;
  logic               pend_L_reg;
  logic               pend_R_reg;
  logic               start_prev_reg;
  logic               dead_L_prev_reg;
  logic               dead_R_prev_reg;
  logic               match_reset_reg;
  logic               freeze_reg;
  logic               respawn_L_reg;
  logic               respawn_R_reg;
  logic [3:0]         kills_L_reg;
  logic [3:0]         kills_R_reg;
  logic [1:0]         winner_reg;

  logic start_edge;
  logic dead_L_edge;
  logic dead_R_edge;
  logic any_death;
  logic board_left_win;
  logic board_right_win;

  assign start_edge      = rc.start  & ~start_prev_reg;
  assign dead_L_edge     = rc.dead_L & ~dead_L_prev_reg;
  assign dead_R_edge     = rc.dead_R & ~dead_R_prev_reg;
  assign any_death       = dead_L_edge | dead_R_edge;
  assign board_left_win  = ($signed(rc.board_controller) == WIN_POS);
  assign board_right_win = ($signed(rc.board_controller) == WIN_NEG);

`ifdef ROUND_CTRL_CLASH_FREEZE_EN
  localparam logic [TIMER_W-1:0] CLASH_LOAD = TIMER_W'(CLASH_CYCLES - 1);

  logic collision_prev_reg;
  logic collision_edge;

  assign collision_edge = rc.collision & ~collision_prev_reg;

  always_ff @(posedge clk) begin
    if (reset) collision_prev_reg <= 1'b0;
    else       collision_prev_reg <= rc.collision;
  end
`endif

  function automatic logic [3:0] sat_inc(input logic [3:0] k);
    return (k == 4'd15) ? k : k + 4'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      timer_reg       <= '0;
      pend_L_reg      <= 1'b0;
      pend_R_reg      <= 1'b0;
      start_prev_reg  <= 1'b0;
      dead_L_prev_reg <= 1'b0;
      dead_R_prev_reg <= 1'b0;
      match_reset_reg <= 1'b1;
      freeze_reg      <= 1'b1;
      respawn_L_reg   <= 1'b0;
      respawn_R_reg   <= 1'b0;
      kills_L_reg     <= 4'd0;
      kills_R_reg     <= 4'd0;
      winner_reg      <= 2'b00;
    end else begin
      start_prev_reg  <= rc.start;
      dead_L_prev_reg <= rc.dead_L;
      dead_R_prev_reg <= rc.dead_R;
      respawn_L_reg   <= 1'b0;
      respawn_R_reg   <= 1'b0;

      case (state_reg)
        IDLE: begin
          match_reset_reg <= 1'b1;
          freeze_reg      <= 1'b1;
          kills_L_reg     <= 4'd0;
          kills_R_reg     <= 4'd0;
          winner_reg      <= 2'b00;
          if (start_edge) begin
            state_reg       <= FIGHT;
            match_reset_reg <= 1'b0;
            freeze_reg      <= 1'b0;
          end
        end

        // A clash pause reacts to deaths exactly like open combat, so both share one path.
        FIGHT, CLASH: begin
          if (state_reg == FIGHT && board_left_win) begin
            state_reg  <= WIN;
            winner_reg <= 2'b01;
            freeze_reg <= 1'b1;
          end else if (state_reg == FIGHT && board_right_win) begin
            state_reg  <= WIN;
            winner_reg <= 2'b10;
            freeze_reg <= 1'b1;
          end else if (any_death) begin
            state_reg  <= RESPAWN;
            timer_reg  <= RESPAWN_LOAD;
            freeze_reg <= 1'b1;
            pend_L_reg <= dead_L_edge;
            pend_R_reg <= dead_R_edge;
            // A double kill scores for nobody.
            if (dead_L_edge && !dead_R_edge) kills_R_reg <= sat_inc(kills_R_reg);
            if (dead_R_edge && !dead_L_edge) kills_L_reg <= sat_inc(kills_L_reg);
`ifdef ROUND_CTRL_CLASH_FREEZE_EN
          end else if (state_reg == FIGHT && collision_edge) begin
            state_reg  <= CLASH;
            timer_reg  <= CLASH_LOAD;
            freeze_reg <= 1'b1;
`endif
          end else if (state_reg == CLASH && timer_reg == '0) begin
            state_reg  <= FIGHT;
            freeze_reg <= 1'b0;
          end else if (state_reg == CLASH) begin
            timer_reg <= timer_reg - 1'b1;
          end
        end

        RESPAWN: begin
          if (timer_reg == '0) begin
            state_reg     <= FIGHT;
            freeze_reg    <= 1'b0;
            respawn_L_reg <= pend_L_reg;
            respawn_R_reg <= pend_R_reg;
            pend_L_reg    <= 1'b0;
            pend_R_reg    <= 1'b0;
          end else begin
            timer_reg <= timer_reg - 1'b1;
          end
        end

        WIN: begin
          if (start_edge) begin
            state_reg       <= IDLE;
            match_reset_reg <= 1'b1;
            freeze_reg      <= 1'b1;
            kills_L_reg     <= 4'd0;
            kills_R_reg     <= 4'd0;
            winner_reg      <= 2'b00;
          end
        end

        default: begin
          state_reg       <= IDLE;
          match_reset_reg <= 1'b1;
          freeze_reg      <= 1'b1;
        end
      endcase
    end
  end

  assign rc.match_reset = match_reset_reg;
  assign rc.freeze      = freeze_reg;
  assign rc.respawn_L   = respawn_L_reg;
  assign rc.respawn_R   = respawn_R_reg;
  assign rc.kills_L     = kills_L_reg;
  assign rc.kills_R     = kills_R_reg;
  assign rc.winner      = winner_reg;
  assign rc.game_state  = state_reg;

endmodule

// File: doc/round_control.md
# round_control

Match-level sequencer for the duel game. Sits above `action_control`: consumes its `dead_L`, `dead_R`, `collision` and `board_controller` outputs, holds it in reset between matches, freezes players during respawn/clash pauses, counts kills, and declares a winner when one player pushes the board far enough. All outputs are registered and drive player movement logic and the HUD.

## Interface
- `RESPAWN_CYCLES`, 65_000_000: length of the respawn freeze (1 s at 65 MHz).
- `CLASH_CYCLES`, 16_250_000: length of the sword-clash freeze (0.25 s).
- `WIN_BOARD`, 3: board index magnitude that ends the match (1..3).
- `TIMER_W`, 26: pause-timer width; must hold `max(RESPAWN_CYCLES, CLASH_CYCLES) - 1`.

- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: start button level, debounced upstream.
- `dead_L` in 1: left player hit, level.
- `dead_R` in 1: right player hit, level.
- `collision` in 1: swords clashed, level.
- `board_controller` in 3: current board index, two's complement.
- `match_reset` out 1: drives `action_control` reset.
- `freeze` out 1: inhibit all player movement/attacks.
- `respawn_L` out 1: one-cycle pulse, return left player to spawn.
- `respawn_R` out 1: one-cycle pulse, return right player to spawn.
- `kills_L` out 4: kills scored by left player.
- `kills_R` out 4: kills scored by right player.
- `winner` out 2: 00 none, 01 left, 10 right.
- `game_state` out 3: current FSM state code.

## Operation
- Rising-edge detectors on `start`, `dead_L`, `dead_R`, `collision`; previous-value registers update every cycle in every state.
- States (code): IDLE 0, FIGHT 1, RESPAWN 2, CLASH 3, WIN 4.
- IDLE: `match_reset`=1, `freeze`=1, kills and `winner` cleared. `start` edge -> FIGHT.
- FIGHT: `match_reset`=0, `freeze`=0. Priority, highest first:
  - `board_controller` == +`WIN_BOARD` -> WIN, `winner`=01.
  - `board_controller` == -`WIN_BOARD` -> WIN, `winner`=10.
  - `dead_L` edge and/or `dead_R` edge -> RESPAWN; timer loaded with `RESPAWN_CYCLES-1`; record the dead player(s) in `pend_L`/`pend_R`. `dead_L` alone: `kills_R`+1. `dead_R` alone: `kills_L`+1. Both in same cycle: double kill, no score change, both pending.
  - `collision` edge -> CLASH (config-dependent); timer loaded with `CLASH_CYCLES-1`.
- RESPAWN: `freeze`=1; timer decrements; death/collision edges ignored. Timer==0 -> FIGHT; `respawn_L`/`respawn_R` pulse for the pending players on the transition edge; pending flags cleared.
- CLASH: `freeze`=1; timer decrements. Death edge -> RESPAWN exactly as from FIGHT. Timer==0 -> FIGHT, no respawn pulses.
- WIN: `freeze`=1, `match_reset`=0, kills and `winner` held. `start` edge -> IDLE.
- Kill counters saturate at 15.
- `board_controller` is compared as signed 3-bit; ±`WIN_BOARD` computed in 3 bits.

## Timing
- Reset values: state IDLE, `match_reset`=1, `freeze`=1, `respawn_L`=`respawn_R`=0, `kills_L`=`kills_R`=0, `winner`=00, `game_state`=0, timer 0, edge registers 0.
- Input sampled at edge n -> state, outputs and kill counts updated after edge n (one-cycle latency).
- RESPAWN lasts exactly `RESPAWN_CYCLES` cycles and CLASH exactly `CLASH_CYCLES` cycles, both counted from state entry.
- A `start` held high across IDLE->FIGHT or WIN->IDLE does not retrigger; a new rising edge is required.
- `reset` mid-pause aborts the timer and suppresses pending respawn pulses.

## Configuration
- `ROUND_CTRL_CLASH_FREEZE_EN` defined: CLASH state active as above.
- Undefined: `collision` ignored, CLASH unreachable, no clash timer load; all other behaviour identical.

## Test plan
Run with `RESPAWN_CYCLES`=8, `CLASH_CYCLES`=4, `WIN_BOARD`=3.
- Reset, `start` pulse -> `game_state` 0->1 one cycle after the edge; `match_reset` and `freeze` fall to 0.
- In FIGHT, `dead_R` rises -> next cycle `game_state`=2, `freeze`=1, `kills_L`=1; 8 cycles later `respawn_R` pulses once, `game_state`=1.
- `dead_L` and `dead_R` rise same cycle -> kills unchanged; both respawn pulses fire together at RESPAWN exit.
- `board_controller`=3'b101 in FIGHT -> `game_state`=4, `winner`=10; `start` edge -> IDLE with kills cleared.
- With macro defined, `collision` edge -> CLASH for 4 cycles, no respawn pulse; undefined -> stays in FIGHT.
- 16 `dead_R` kills -> `kills_L` saturates at 15; `reset` asserted during RESPAWN -> IDLE next cycle, no respawn pulse.
